sobel_edge: RTL and testbench

- Streaming 3x3 Sobel gradient stage, sitting directly upstream of the edge-select/overlay stage.
- Consumes one 8-bit greyscale pixel per valid cycle and produces one 8-bit edge code per pixel.
- Edge code 8'hFF means "no edge" (downstream treats it as transparent).
- Any other value is an edge, darker for stronger gradient.

---
 rtl/edge_pkg.sv | 13 +
 rtl/sobel_edge_if.sv | 17 +
 rtl/line_buffer.sv | 21 ++
 rtl/sobel_edge.sv | 135 +++++++++++++
 tb/tb_sobel_edge.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// Shared constants, window type and saturation helper for the Sobel edge stage.
package edge_pkg;
  localparam int              PIX_W   = 8;
  localparam int              GRAD_W  = 11;
  localparam logic [PIX_W-1:0] NO_EDGE = 8'hFF;

  // win[row][col]: row 0 is the oldest line (top), col 0 the oldest pixel (left).
  typedef logic [2:0][2:0][PIX_W-1:0] window_t;

  function automatic logic [PIX_W-1:0] sat8(input logic [GRAD_W-1:0] mag);
    sat8 = (mag > GRAD_W'(255)) ? 8'hFF : mag[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/sobel_edge_if.sv
// Pixel-in / edge-out stream bundle for sobel_edge.
// Valid-only stream: no back-pressure, each *_valid high marks exactly one beat that
// must be consumed in that cycle; frame_start qualifies only a beat with pixel_valid high.
interface sobel_edge_if;
  import edge_pkg::*;
  logic             frame_start;
  logic             pixel_valid;
  logic [PIX_W-1:0] pixel_in;
  logic [PIX_W-1:0] threshold;
  logic             edge_valid;
  logic [PIX_W-1:0] edge_out;

  modport master (output frame_start, pixel_valid, pixel_in, threshold,
                  input  edge_valid, edge_out);
  modport slave  (input  frame_start, pixel_valid, pixel_in, threshold,
                  output edge_valid, edge_out);
endinterface

// File: rtl/line_buffer.sv
// One video line of storage; the read port returns the pre-write contents of addr,
// so a write and the consuming register capture happen on the same clock edge.
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wr_data;
  end
endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel magnitude stage, 3-cycle fixed latency, 8'hFF = no edge.
// Define EDGE_COUNT_EN to add the per-frame edge_count output.
module sobel_edge import edge_pkg::*; #(
  parameter int LINE_WIDTH = 640,
  parameter int COL_W      = 10
) (
  input  logic           clock,
  input  logic           reset,
  sobel_edge_if.slave    px
`ifdef EDGE_COUNT_EN
  ,
  output logic [19:0]    edge_count
`endif
);
  localparam logic [10:0] ROW_MAX = 11'd2047;

  logic [COL_W-1:0]  col, cur_col, nxt_col;
  logic [10:0]       row, cur_row, nxt_row;
  logic [PIX_W-1:0]  lb0_rd, lb1_rd;
  window_t           win;
  logic              border_s1, valid_s1, border_s2, valid_s2;
  logic [GRAD_W-1:0] gx_c, gy_c, gx, gy, abs_gx, abs_gy, mag;
  logic [PIX_W-1:0]  thr_eff, code;

  function automatic logic [GRAD_W-1:0] w1(input logic [PIX_W-1:0] p);
    w1 = GRAD_W'(p);
  endfunction

  function automatic logic [GRAD_W-1:0] w2(input logic [PIX_W-1:0] p);
    w2 = GRAD_W'({p, 1'b0});
  endfunction

  // frame_start retargets the current pixel to (0,0) without waiting a cycle.
  always_comb begin
    cur_col = px.frame_start ? '0 : col;
    cur_row = px.frame_start ? '0 : row;
    nxt_col = (cur_col == COL_W'(LINE_WIDTH - 1)) ? '0 : cur_col + 1'b1;
    nxt_row = cur_row;
    if (cur_col == COL_W'(LINE_WIDTH - 1) && cur_row != ROW_MAX) nxt_row = cur_row + 1'b1;
  end

  line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_lb0 (
    .clock(clock), .we(px.pixel_valid), .addr(cur_col), .wr_data(px.pixel_in), .rd_data(lb0_rd)
  );

  line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_lb1 (
    .clock(clock), .we(px.pixel_valid), .addr(cur_col), .wr_data(lb0_rd), .rd_data(lb1_rd)
  );

  // S1: counters, window shift and border flag, all gated by pixel_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      win       <= '0;
      border_s1 <= 1'b1;
      valid_s1  <= 1'b0;
    end else begin
      valid_s1 <= px.pixel_valid;
      if (px.pixel_valid) begin
        col <= nxt_col;
        row <= nxt_row;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= px.pixel_in;
        border_s1 <= (cur_row < 11'd2) || (cur_col < COL_W'(2));
      end
    end
  end

  // Gradients are held as 11-bit two's complement; range fits without overflow.
  always_comb begin
    gx_c = (w1(win[0][2]) + w2(win[1][2]) + w1(win[2][2]))
         - (w1(win[0][0]) + w2(win[1][0]) + w1(win[2][0]));
    gy_c = (w1(win[2][0]) + w2(win[2][1]) + w1(win[2][2]))
         - (w1(win[0][0]) + w2(win[0][1]) + w1(win[0][2]));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gx        <= '0;
      gy        <= '0;
      border_s2 <= 1'b1;
      valid_s2  <= 1'b0;
    end else begin
      gx        <= gx_c;
      gy        <= gy_c;
      border_s2 <= border_s1;
      valid_s2  <= valid_s1;
    end
  end

  always_comb begin
    abs_gx  = gx[GRAD_W-1] ? (~gx + 1'b1) : gx;
    abs_gy  = gy[GRAD_W-1] ? (~gy + 1'b1) : gy;
    mag     = abs_gx + abs_gy;
    thr_eff = (px.threshold == '0) ? 8'd1 : px.threshold;
    code    = (!border_s2 && mag >= GRAD_W'(thr_eff)) ? ~sat8(mag) : NO_EDGE;
  end

  // S3: edge_out only moves on a valid beat so downstream sees a stable code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px.edge_valid <= 1'b0;
      px.edge_out   <= NO_EDGE;
    end else begin
      px.edge_valid <= valid_s2;
      if (valid_s2) px.edge_out <= code;
    end
  end

`ifdef EDGE_COUNT_EN
  logic [19:0] edge_run;
  logic        out_edge;

  assign out_edge = px.edge_valid && (px.edge_out != NO_EDGE);

  // An edge leaving in the frame_start cycle belongs to the new frame's count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_run   <= '0;
      edge_count <= '0;
    end else if (px.frame_start && px.pixel_valid) begin
      edge_count <= edge_run;
      edge_run   <= {19'b0, out_edge};
    end else if (out_edge && edge_run != '1) begin
      edge_run <= edge_run + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge: image-level Sobel model, per-cycle compare, literal pins.
module tb_sobel_edge;
  import edge_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sobel_edge_if bus ();
`ifdef EDGE_COUNT_EN
  logic [19:0] edge_count;
`endif

  sobel_edge #(.LINE_WIDTH(W), .COL_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .px    (bus.slave)
`ifdef EDGE_COUNT_EN
    ,
    .edge_count (edge_count)
`endif
  );

  // ---------------- model state ----------------
  int          img [H][W];
  logic [7:0]  got [H*W];
  logic [7:0]  step_ref [H*W];
  logic [7:0]  exp_q [$];
  int          idx_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected code for the pixel at (r,c), straight from the Sobel definition on the image.
  function automatic logic [7:0] model_code(input int r, input int c, input int thr);
    int gx, gy, mag, t, s;
    if (r < 2 || c < 2) return 8'hFF;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    mag = iabs(gx) + iabs(gy);
    t   = (thr == 0) ? 1 : thr;
    if (mag < t) return 8'hFF;
    s = (mag > 255) ? 255 : mag;
    return 8'(255 - s);
  endfunction

  // kind: 0 flat 0x80, 1 vertical step at column 4, 2 horizontal ramp +1 per column
  task automatic fill_img(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 8'h80;
          1:       img[r][c] = (c < 4) ? 0 : 255;
          default: img[r][c] = 16 + c;
        endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fs, input logic pv, input logic [7:0] pix);
    bus.frame_start = fs;
    bus.pixel_valid = pv;
    bus.pixel_in    = pix;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bus.frame_start = 1'b0;
    bus.pixel_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input int kind, input int thr, input bit gapped, input int npix);
    int r, c;
    fill_img(kind);
    bus.threshold = 8'(thr);
    for (int k = 0; k < npix; k++) begin
      r = k / W;
      c = k % W;
      exp_q.push_back(model_code(r, c, thr));
      idx_q.push_back(k);
      drive(k == 0, 1'b1, 8'(img[r][c]));
      // idle beat carries a stray frame_start that must be ignored
      if (gapped && k < npix - 1) drive(1'b1, 1'b0, 8'h33);
    end
    idle(5);
  endtask

  // ---------------- scoreboard / compare ----------------
  logic [2:0] vhist;
  logic [7:0] last_exp = 8'hFF;

  always @(posedge clock or posedge reset) begin
    if (reset) vhist <= '0;
    else       vhist <= {vhist[1:0], bus.pixel_valid};
  end

  always @(negedge clock) begin
    if (reset) begin
      last_exp = 8'hFF;
      exp_q.delete();
      idx_q.delete();
    end else begin
      check("edge_valid", {31'b0, bus.edge_valid}, {31'b0, vhist[2]});
      if (vhist[2]) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'd1, 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
          got[idx_q.pop_front()] = bus.edge_out;
        end
      end
      check("edge_out", {24'b0, bus.edge_out}, {24'b0, last_exp});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.frame_start = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = 8'h00;
    bus.threshold   = 8'd10;
    for (int k = 0; k < H*W; k++) got[k] = 8'h5A;
    repeat (3) @(posedge clock);
    #1;
    check("reset_edge_valid", {31'b0, bus.edge_valid}, 32'd0);
    check("reset_edge_out", {24'b0, bus.edge_out}, 32'hFF);
`ifdef EDGE_COUNT_EN
    check("reset_edge_count", {12'b0, edge_count}, 32'd0);
`endif
    reset = 1'b0;
    idle(2);

    // flat frame: no gradient anywhere
    send_frame(0, 10, 1'b0, H*W);
    check("flat_r2c4", {24'b0, got[2*W+4]}, 32'hFF);
    check("flat_r7c7", {24'b0, got[7*W+7]}, 32'hFF);

    // vertical step: centre columns 3 and 4 see |Gx| = 1020
    send_frame(1, 10, 1'b0, H*W);
    check("step_r2c4", {24'b0, got[2*W+4]}, 32'h00);
    check("step_r2c5", {24'b0, got[2*W+5]}, 32'h00);
    check("step_r2c3", {24'b0, got[2*W+3]}, 32'hFF);
    check("step_r2c6", {24'b0, got[2*W+6]}, 32'hFF);
    check("step_r1c4_border", {24'b0, got[1*W+4]}, 32'hFF);
    check("step_r3c1_wrap", {24'b0, got[3*W+1]}, 32'hFF);
    check("step_r7c5", {24'b0, got[7*W+5]}, 32'h00);
    for (int k = 0; k < H*W; k++) step_ref[k] = got[k];

    // ramp gives magnitude 8: threshold decides
    send_frame(2, 9, 1'b0, 4*W);
    check("ramp_thr9", {24'b0, got[3*W+4]}, 32'hFF);
    send_frame(2, 8, 1'b0, 4*W);
    check("ramp_thr8", {24'b0, got[3*W+4]}, 32'hF7);
    check("ramp_thr8_border", {24'b0, got[1*W+4]}, 32'hFF);
    send_frame(2, 0, 1'b0, 4*W);
    check("ramp_thr0", {24'b0, got[3*W+4]}, 32'hF7);

    // gapped step frame must match the gap-free one pixel for pixel
    send_frame(1, 10, 1'b1, H*W);
    for (int k = 0; k < H*W; k++) check("gapped_vs_ref", {24'b0, got[k]}, {24'b0, step_ref[k]});

    // reset in row 3, right after an edge has been output
    fill_img(1);
    bus.threshold = 8'd10;
    for (int k = 0; k < 3*W + 6; k++) begin
      exp_q.push_back(model_code(k / W, k % W, 10));
      idx_q.push_back(k);
      drive(k == 0, 1'b1, 8'(img[k / W][k % W]));
    end
    idle(4);
    check("pre_reset_edge_out", {24'b0, bus.edge_out}, 32'h00);
    reset = 1'b1;
    #1;
    check("async_reset_edge_valid", {31'b0, bus.edge_valid}, 32'd0);
    check("async_reset_edge_out", {24'b0, bus.edge_out}, 32'hFF);
    idle(2);
    reset = 1'b0;
    idle(2);

    send_frame(1, 10, 1'b0, H*W);
    check("post_reset_r1c4", {24'b0, got[1*W+4]}, 32'hFF);
    check("post_reset_r2c1", {24'b0, got[2*W+1]}, 32'hFF);
    check("post_reset_r2c4", {24'b0, got[2*W+4]}, 32'h00);

`ifdef EDGE_COUNT_EN
    send_frame(0, 10, 1'b0, 1);
    check("edge_count_step", {12'b0, edge_count}, 32'd12);
`endif

    idle(3);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
